// File: rtl/zigzag_ctrl_pkg.sv
// Shared types and constants for the FDCT-to-zigzag sequencer: state encoding,
// counter geometry and the JPEG zigzag scan table.
package jpeg_zz_pkg;

    localparam int N_COEF = 64;
    localparam int CNT_W  = $clog2(N_COEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } zz_state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO   = 6'd0;
    localparam logic [CNT_W-1:0] CNT_ONE    = 6'd1;
    localparam logic [CNT_W-1:0] CNT_PENULT = 6'd62;
    localparam logic [CNT_W-1:0] CNT_LAST   = 6'd63;

    // Raster position of each beat of the standard JPEG zigzag scan.
    localparam logic [CNT_W-1:0] ZZ_TABLE [N_COEF] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic logic [CNT_W-1:0] zz_lookup(input logic [CNT_W-1:0] cnt);
        return ZZ_TABLE[cnt];
    endfunction

endpackage

// File: rtl/zigzag_ctrl_if.sv
// Control/stream bundle between the zigzag sequencer and its surroundings
// (FDCT completion in, coefficient handshake and status out).
interface zigzag_ctrl_if;
    import jpeg_zz_pkg::*;

    logic             ena;
    logic             dct_done;
    logic             out_ready;
    logic             clr_err;
    logic             ld_zigzag;
    logic             dout_valid;
    logic [CNT_W-1:0] zz_cnt;
    logic [CNT_W-1:0] zz_idx;
    logic             last;
    logic             block_done;
    logic             busy;
    logic             overrun;

    modport master (
        output ena, dct_done, out_ready, clr_err,
        input  ld_zigzag, dout_valid, zz_cnt, zz_idx, last, block_done, busy, overrun
    );

    modport slave (
        input  ena, dct_done, out_ready, clr_err,
        output ld_zigzag, dout_valid, zz_cnt, zz_idx, last, block_done, busy, overrun
    );

endinterface

// File: rtl/zigzag_ctrl_index_rom.sv
// Combinational zigzag lookup: beat number to raster coefficient index.
module zz_index_rom
    import jpeg_zz_pkg::*;
(
    input  logic [CNT_W-1:0] i_cnt,
    output logic [CNT_W-1:0] o_idx
);

    assign o_idx = zz_lookup(i_cnt);

endmodule

// File: rtl/zigzag_ctrl.sv
// Sequencer that loads an FDCT block into the sresult array and drains it
// in zigzag order, with a one-deep pending queue and sticky overrun flag.
module zigzag_ctrl
    import jpeg_zz_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    zigzag_ctrl_if.slave bus
);

    zz_state_t        r_state;
    logic             r_pending;
    logic             r_overrun;
    logic             r_ld;
    logic             r_valid;
    logic             r_last;
    logic             r_block_done;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_idx;

    logic w_at_last;
    logic w_accept;
    logic w_consume;
    logic w_direct;
    logic w_set_pending;
    logic w_ovr_evt;

    zz_index_rom u_rom (
        .i_cnt (r_cnt),
        .o_idx (w_idx)
    );

    assign w_at_last = (r_cnt == CNT_LAST);
    assign w_accept  = r_valid & bus.out_ready & bus.ena;
    // Pending is taken either from IDLE or at the end of a drain.
    assign w_consume = bus.ena & r_pending & ((r_state == IDLE) | (w_accept & w_at_last));
    // An idle, enabled controller starts the block itself instead of queueing it.
    assign w_direct      = bus.ena & (r_state == IDLE) & ~r_pending;
    assign w_set_pending = bus.dct_done & ~w_direct;
    assign w_ovr_evt     = bus.dct_done & r_pending & ~w_consume;

    // Sequencer state, beat counter, pending queue and sticky overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_pending    <= 1'b0;
            r_overrun    <= 1'b0;
            r_ld         <= 1'b0;
            r_valid      <= 1'b0;
            r_last       <= 1'b0;
            r_block_done <= 1'b0;
            r_busy       <= 1'b0;
            r_cnt        <= CNT_ZERO;
        end else begin
            if (w_set_pending) begin
                r_pending <= 1'b1;
            end else if (w_consume) begin
                r_pending <= 1'b0;
            end

            if (w_ovr_evt) begin
                r_overrun <= 1'b1;
            end else if (bus.clr_err) begin
                r_overrun <= 1'b0;
            end

            if (bus.ena) begin
                r_block_done <= 1'b0;
                case (r_state)
                    IDLE: begin
                        if (bus.dct_done || r_pending) begin
                            r_state <= LOAD;
                            r_ld    <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                    LOAD: begin
                        r_state <= DRAIN;
                        r_ld    <= 1'b0;
                        r_valid <= 1'b1;
                        r_last  <= 1'b0;
                        r_cnt   <= CNT_ZERO;
                    end
                    DRAIN: begin
                        if (w_accept) begin
                            if (w_at_last) begin
                                r_valid      <= 1'b0;
                                r_last       <= 1'b0;
                                r_cnt        <= CNT_ZERO;
                                r_block_done <= 1'b1;
                                if (r_pending) begin
                                    r_state <= LOAD;
                                    r_ld    <= 1'b1;
                                end else begin
                                    r_state <= IDLE;
                                    r_busy  <= 1'b0;
                                end
                            end else begin
                                r_cnt  <= r_cnt + CNT_ONE;
                                r_last <= (r_cnt == CNT_PENULT);
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_ld    <= 1'b0;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_cnt   <= CNT_ZERO;
                    end
                endcase
            end
        end
    end

    // Strobes are held while frozen and only shown on enabled cycles.
    assign bus.ld_zigzag  = r_ld & bus.ena;
    assign bus.block_done = r_block_done & bus.ena;
    assign bus.dout_valid = r_valid;
    assign bus.zz_cnt     = r_cnt;
    assign bus.zz_idx     = w_idx;
    assign bus.last       = r_last;
    assign bus.busy       = r_busy;
    assign bus.overrun    = r_overrun;

endmodule

// File: doc/zigzag_ctrl.md
Name: zigzag_ctrl

Overview:
- Sequencer for the FDCT-to-zigzag stage of jpeg_encoder.
- Issues the ld_zigzag strobe that parallel-loads the 64-entry sresult register array.
- Drains the loaded block one coefficient per accepted beat, generating the zigzag scan index.
- Queues one pending block from the FDCT, flags overruns and signals block completion to the quantizer side.

Parameters:
- N_COEF, 64, coefficients per 8x8 block; fixed at 64, elaborated for checking only.
- CNT_W, 6, width of the beat counter and index outputs; equals log2(N_COEF).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- ena  input  1  global clock enable, shared with the fdct/zigzag datapath.
- dct_done  input  1  one-cycle pulse: FDCT block result ready to load.
- out_ready  input  1  downstream accepts the current coefficient.
- clr_err  input  1  synchronous clear of the sticky overrun flag.
- ld_zigzag  output  1  one-cycle load strobe to the sresult register array.
- dout_valid  output  1  current coefficient valid.
- zz_cnt  output  CNT_W  beat number within the block, 0..63.
- zz_idx  output  CNT_W  raster index of the current coefficient: ZZ_TABLE[zz_cnt].
- last  output  1  high with dout_valid when zz_cnt==63.
- block_done  output  1  one-cycle pulse after the beat with zz_cnt==63 is accepted.
- busy  output  1  high in LOAD or DRAIN.
- overrun  output  1  sticky: dct_done arrived with pending already set.

Behaviour:
- Reset (rst=0, asynchronous) values:
  - state=IDLE, pending=0, cnt=0, overrun=0.
  - All outputs 0, so zz_idx=ZZ_TABLE[0]=0.
- States: IDLE, LOAD, DRAIN.
- IDLE:
  - dct_done (or pending) with ena=1 → LOAD.
  - pending clears in that same cycle.
- LOAD:
  - ld_zigzag=1 for exactly one ena-qualified cycle, then → DRAIN with cnt=0.
  - dout_valid=0 in LOAD.
- DRAIN:
  - dout_valid=1 throughout.
  - A beat is accepted when dout_valid & out_ready & ena; cnt increments on each accepted beat.
  - zz_cnt, zz_idx and last hold stable while out_ready=0.
  - Accept at cnt=63: block_done pulses the next cycle.
    - pending=1 → LOAD (back-to-back, no IDLE cycle); pending clears.
    - Otherwise → IDLE.
- Latency: dct_done at cycle t (IDLE, ena=1) → ld_zigzag at t+1 → first dout_valid at t+2.
- Pending queue:
  - dct_done in LOAD or DRAIN sets pending.
  - dct_done while pending=1 sets overrun; the extra block is dropped and pending stays 1.
  - dct_done in the same cycle as the pending-consume transition re-sets pending. Set wins over clear.
- ena=0:
  - state, cnt and ld_zigzag sequencing freeze.
  - ld_zigzag and block_done are gated to 0.
  - dout_valid is held at its frozen value but no beat is accepted.
  - dct_done is still captured into pending/overrun, so no pulse is lost.
- clr_err clears overrun. A simultaneous overrun event wins, leaving overrun=1.
- Reset mid-DRAIN: immediate return to IDLE. The partial block is abandoned and pending is lost.
- cnt is CNT_W bits and never wraps inside DRAIN; it resets to 0 on LOAD exit.
- ZZ_TABLE is the standard JPEG zigzag order:
  - Starts 0,1,8,16,9,2,3,10,17,24,…
  - Ends …,47,55,62,63.

Decomposition:
- Shared package jpeg_zz_pkg holds:
  - N_COEF and CNT_W constants;
  - the zz_state_t enum (IDLE, LOAD, DRAIN);
  - the ZZ_TABLE constant array of 64 × 6-bit.
- One sub-module: zz_index_rom, a combinational ZZ_TABLE lookup, cnt → zz_idx. It is reused by the zigzag readback checker.

Test Plan:
- Single block: dct_done at t, out_ready=1, ena=1 → ld_zigzag at t+1; dout_valid t+2..t+65; zz_idx sequence 0,1,8,16,9,…,62,63; last at t+65; block_done at t+66; busy low at t+66.
- Backpressure: out_ready toggled 1/0 every cycle → 128 DRAIN cycles; zz_cnt/zz_idx stable while out_ready=0; exactly 64 accepted beats.
- Back-to-back: second dct_done at t+20 → pending=1; after accepting beat 63, ld_zigzag with no IDLE cycle; second block drains 0..63; overrun stays 0.
- Overrun: three dct_done pulses at t, t+10, t+20 → overrun=1 from t+21; exactly two blocks drained; clr_err then clears overrun to 0.
- ena gating: ena=0 for 5 cycles mid-DRAIN at cnt=30 → zz_cnt held at 30, no beats accepted; a dct_done during the freeze still sets pending.
- Async reset: rst low at cnt=40 → all outputs 0 within the same cycle; next dct_done restarts from zz_cnt=0.
